// File: rtl/order_stat_sort_pkg.sv
// order_stat_pkg: shared types and helpers for the order-statistics sorter.
//   pixel_t        default-width pixel type (modules re-derive it from their
//                  own DATA_WIDTH parameter)
//   cmp_word_t     wide unsigned word used by the shared compare-exchange
//   cmp_swap(a,b)  returns {min, max}; equal inputs come back unswapped
//   stage_parity   pair offset used by odd-even transposition stage s
package order_stat_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  // Compare width; supports DATA_WIDTH up to 32 bits (zero-extended).
  localparam int CMP_W = 32;

  typedef logic [DEF_DATA_WIDTH-1:0] pixel_t;
  typedef logic [CMP_W-1:0]          cmp_word_t;

  // Unsigned compare-exchange. Swap only when a > b, so equal values keep
  // their order.
  function automatic logic [2*CMP_W-1:0] cmp_swap(input cmp_word_t a,
                                                  input cmp_word_t b);
    if (a > b) return {b, a};
    else       return {a, b};
  endfunction

  // Stage s exchanges pairs (i, i+1) with i = s mod 2.
  function automatic int stage_parity(input int s);
    return s % 2;
  endfunction

endpackage

// File: rtl/order_stat_sort_if.sv
// order_stat_sort_if: window-in / sorted-window-out stream bundle.
//   din_*  : window (element i at [i*DATA_WIDTH +: DATA_WIDTH]), rank select,
//            valid, ready
//   dout_* : selected element, full ascending vector, applied rank, valid,
//            ready
// Handshake (both streams): a transfer happens on a rising clk edge where
// valid & ready are both 1. The producer holds valid and its payload stable
// until that transfer; ready may depend combinationally on the consumer's
// ready.
//   master : environment side (drives din_*, dout_ready)
//   slave  : engine side (drives din_ready, dout_*)
interface order_stat_sort_if #(
  parameter int DATA_WIDTH = 8,
  parameter int WIN_SIZE   = 9,
  parameter int RANK_W     = $clog2(WIN_SIZE)
);
  logic [WIN_SIZE*DATA_WIDTH-1:0] din_data;
  logic [RANK_W-1:0]              din_rank;
  logic                           din_valid;
  logic                           din_ready;
  logic [DATA_WIDTH-1:0]          dout_data;
  logic [WIN_SIZE*DATA_WIDTH-1:0] dout_sorted;
  logic [RANK_W-1:0]              dout_rank;
  logic                           dout_valid;
  logic                           dout_ready;

  modport master (
    output din_data, din_rank, din_valid, dout_ready,
    input  din_ready, dout_data, dout_sorted, dout_rank, dout_valid
  );

  modport slave (
    input  din_data, din_rank, din_valid, dout_ready,
    output din_ready, dout_data, dout_sorted, dout_rank, dout_valid
  );
endinterface

// File: rtl/order_stat_sort_stage.sv
// order_stat_stage: one layer of the odd-even transposition network.
//   clk, arstn       clock, synchronous active-low reset
//   en               load enable (global pipeline advance)
//   in_data/rank/valid  predecessor stage contents
//   q_data/rank/valid   registered result after this layer's exchanges
module order_stat_stage
  import order_stat_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int WIN_SIZE   = 9,
  parameter int PARITY     = 0,
  parameter int RANK_W     = $clog2(WIN_SIZE)
) (
  input  logic                           clk,
  input  logic                           arstn,
  input  logic                           en,
  input  logic [WIN_SIZE*DATA_WIDTH-1:0] in_data,
  input  logic [RANK_W-1:0]              in_rank,
  input  logic                           in_valid,
  output logic [WIN_SIZE*DATA_WIDTH-1:0] q_data,
  output logic [RANK_W-1:0]              q_rank,
  output logic                           q_valid
);

  typedef logic [DATA_WIDTH-1:0] pix_t;

  logic [WIN_SIZE*DATA_WIDTH-1:0] ex_data;
  pix_t                           elem_a;
  pix_t                           elem_b;
  logic [2*CMP_W-1:0]             pair;

  // Pairs within one layer are disjoint, so every pair reads in_data
  // directly. A swap happened exactly when cmp_swap reordered its inputs.
  always_comb begin
    ex_data = in_data;
    elem_a  = '0;
    elem_b  = '0;
    pair    = '0;
    for (int i = PARITY; i + 1 < WIN_SIZE; i += 2) begin
      elem_a = in_data[i*DATA_WIDTH +: DATA_WIDTH];
      elem_b = in_data[(i+1)*DATA_WIDTH +: DATA_WIDTH];
      pair   = cmp_swap(cmp_word_t'(elem_a), cmp_word_t'(elem_b));
      if (pair != {cmp_word_t'(elem_a), cmp_word_t'(elem_b)}) begin
        ex_data[i*DATA_WIDTH +: DATA_WIDTH]     = elem_b;
        ex_data[(i+1)*DATA_WIDTH +: DATA_WIDTH] = elem_a;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!arstn) begin
      q_data  <= '0;
      q_rank  <= '0;
      q_valid <= 1'b0;
    end else if (en) begin
      q_data  <= ex_data;
      q_rank  <= in_rank;
      q_valid <= in_valid;
    end
  end

endmodule

// File: rtl/order_stat_sort.sv
// order_stat_sort: pipelined order-statistics engine. Each accepted window
// is fully sorted by WIN_SIZE odd-even transposition stages; the element at
// the window's own (clamped) rank is muxed out of the last stage.
//   clk, arstn  clock, synchronous active-low reset
//   bus         order_stat_sort_if slave: din_* window stream in,
//               dout_* sorted result stream out (with backpressure)
// The whole pipeline advances together (adv = dout_ready | ~dout_valid);
// bubbles are kept, not collapsed.
module order_stat_sort
  import order_stat_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int WIN_SIZE   = 9,
  parameter int RANK_W     = $clog2(WIN_SIZE)
) (
  input logic               clk,
  input logic               arstn,
  order_stat_sort_if.slave  bus
);

  logic [WIN_SIZE*DATA_WIDTH-1:0] stg_data  [WIN_SIZE];
  logic [RANK_W-1:0]              stg_rank  [WIN_SIZE];
  logic                           stg_valid [WIN_SIZE];
  logic [RANK_W-1:0]              rank_clamped;
  logic                           adv;

  assign adv           = bus.dout_ready | ~stg_valid[WIN_SIZE-1];
  assign bus.din_ready = adv;

  // Out-of-range ranks select the maximum. Compared as int so the limit is
  // correct even when WIN_SIZE is a power of two and does not fit RANK_W.
  always_comb begin
    rank_clamped = bus.din_rank;
    if (int'(bus.din_rank) >= WIN_SIZE) rank_clamped = RANK_W'(WIN_SIZE - 1);
  end

  for (genvar s = 0; s < WIN_SIZE; s++) begin : g_stage
    if (s == 0) begin : g_first
      order_stat_stage #(
        .DATA_WIDTH (DATA_WIDTH),
        .WIN_SIZE   (WIN_SIZE),
        .PARITY     (stage_parity(s)),
        .RANK_W     (RANK_W)
      ) u_stage (
        .clk      (clk),
        .arstn    (arstn),
        .en       (adv),
        .in_data  (bus.din_data),
        .in_rank  (rank_clamped),
        .in_valid (bus.din_valid),
        .q_data   (stg_data[s]),
        .q_rank   (stg_rank[s]),
        .q_valid  (stg_valid[s])
      );
    end else begin : g_next
      order_stat_stage #(
        .DATA_WIDTH (DATA_WIDTH),
        .WIN_SIZE   (WIN_SIZE),
        .PARITY     (stage_parity(s)),
        .RANK_W     (RANK_W)
      ) u_stage (
        .clk      (clk),
        .arstn    (arstn),
        .en       (adv),
        .in_data  (stg_data[s-1]),
        .in_rank  (stg_rank[s-1]),
        .in_valid (stg_valid[s-1]),
        .q_data   (stg_data[s]),
        .q_rank   (stg_rank[s]),
        .q_valid  (stg_valid[s])
      );
    end
  end

  assign bus.dout_sorted = stg_data[WIN_SIZE-1];
  assign bus.dout_rank   = stg_rank[WIN_SIZE-1];
  assign bus.dout_valid  = stg_valid[WIN_SIZE-1];

  // Rank select. The stored rank is already clamped, so exactly one
  // element matches.
  always_comb begin
    bus.dout_data = '0;
    for (int i = 0; i < WIN_SIZE; i++) begin
      if (stg_rank[WIN_SIZE-1] == RANK_W'(i))
        bus.dout_data = stg_data[WIN_SIZE-1][i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule
